// File: rtl/mips_pkg.sv
// Shared MIPS constants for the register bank and its scoreboard.
// No ports: this file holds only localparams.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;
  localparam int unsigned SP_RST   = 227;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register bank.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   iss_valid, iss_addr   mark a destination as pending (issue)
//   wr_en, wr_addr        clear a destination on write-back
//   pending               one bit per register, bit 0 is never set
//   pend_cnt              registered popcount of pending
module reg_scoreboard #(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  output logic [(2**ADDR_W)-1:0]  pending,
  output logic [ADDR_W:0]         pend_cnt
);
  import mips_pkg::*;

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending_q, pending_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            iss_hit, wr_hit, inc, dec;

  assign iss_hit = iss_valid && (iss_addr != ADDR_W'(REG_ZERO));
  assign wr_hit  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  always_comb begin
    pending_d = pending_q;
    // Clear first so a same-index issue (newer producer) overrides it.
    if (wr_hit)  pending_d[wr_addr]  = 1'b0;
    if (iss_hit) pending_d[iss_addr] = 1'b1;

    inc = iss_hit && !pending_q[iss_addr];
    dec = wr_hit && pending_q[wr_addr] && !(iss_hit && (iss_addr == wr_addr));

    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_bank_wb.sv
// 32 x 32-bit MIPS register bank with registered write-back, optional
// write-to-read bypass and a per-register pending scoreboard.
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-low reset
//   rd_addr_a/b, rd_data_a/b       combinational read ports (rs / rt)
//   rd_busy_a/b                    addressed register has a pending write
//   iss_valid, iss_addr            destination issued (mark pending)
//   wr_en, wr_addr, wr_data        write-back
//   pend_cnt                       number of pending registers
module reg_bank_wb #(
  parameter int unsigned          DATA_W = mips_pkg::DATA_W,
  parameter int unsigned          ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned          SP_IDX = mips_pkg::REG_SP,
  parameter logic [DATA_W-1:0]    SP_RST = DATA_W'(mips_pkg::SP_RST),
  parameter bit                   BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  output logic               rd_busy_a,
  output logic               rd_busy_b,
  input  logic               iss_valid,
  input  logic [ADDR_W-1:0]  iss_addr,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [ADDR_W:0]    pend_cnt
);
  import mips_pkg::*;

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pending;
  logic              wr_hit, iss_hit;

  assign wr_hit  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
  assign iss_hit = iss_valid && (iss_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_a = pending[rd_addr_a];
    rd_busy_b = pending[rd_addr_b];
    if (BYPASS) begin
      if (wr_hit && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
        // A same-cycle issue keeps the register busy for the newer producer.
        if (!(iss_hit && (iss_addr == rd_addr_a))) rd_busy_a = 1'b0;
      end
      if (wr_hit && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
        if (!(iss_hit && (iss_addr == rd_addr_b))) rd_busy_b = 1'b0;
      end
    end
    if (rd_addr_a == ADDR_W'(REG_ZERO)) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
    if (rd_addr_b == ADDR_W'(REG_ZERO)) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end

endmodule
